// File: rtl/lcd_frame_stream_source.sv
// Avalon-MM to 8-bit Avalon-ST frame source feeding the LCD dual-clock FIFO write side.
// Optional build macro LCD_FRAME_STREAM_IRQ_EN adds an end-of-frame interrupt output.
module lcd_frame_stream_source #(
    parameter int unsigned FRAME_BYTES_W = 20,
    parameter bit          MSB_FIRST     = 1'b0
) (
    input  logic        wrclk,
    input  logic        wrreset_n,
    input  logic [1:0]  avs_address,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    output logic        avs_waitrequest,
    output logic [7:0]  st_data,
    output logic        st_valid,
    output logic        st_startofpacket,
    output logic        st_endofpacket,
    input  logic        st_ready
`ifdef LCD_FRAME_STREAM_IRQ_EN
    ,
    output logic        irq
`endif
);
    localparam logic [1:0] ADDR_CONTROL = 2'd0;
    localparam logic [1:0] ADDR_FRAME   = 2'd1;
    localparam logic [1:0] ADDR_DATA    = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;
    localparam int unsigned REM_FIELD_W = 24;

    typedef enum logic {S_IDLE, S_STREAM} state_t;

    state_t                   state;
    logic [FRAME_BYTES_W-1:0] frame_bytes;
    logic [FRAME_BYTES_W-1:0] remaining;
    logic                     sof_pend;
    logic                     hb_valid;
    logic [31:0]              hb;
    logic [31:0]              sr;
    logic [2:0]               sr_cnt;
    logic                     st_drop;
    logic                     st_zero_len;
    logic                     st_eof;
    logic                     irq_enable;

    logic        wr_ctrl, wr_frame, wr_data_req, wr_stat;
    logic        start, abort, streaming;
    logic        xfer, last_xfer, sr_free, data_acc;
    logic [31:0] word_in;

    assign wr_ctrl     = avs_write && (avs_address == ADDR_CONTROL);
    assign wr_frame    = avs_write && (avs_address == ADDR_FRAME);
    assign wr_data_req = avs_write && (avs_address == ADDR_DATA);
    assign wr_stat     = avs_write && (avs_address == ADDR_STATUS);
    assign abort       = wr_ctrl && avs_writedata[1];
    assign start       = wr_ctrl && avs_writedata[0] && !avs_writedata[1];
    assign streaming   = (state == S_STREAM);

    // sr always shifts right, so byte order is fixed up once at capture time
    assign word_in = MSB_FIRST ? {avs_writedata[7:0], avs_writedata[15:8],
                                  avs_writedata[23:16], avs_writedata[31:24]}
                               : avs_writedata;

    assign st_valid         = streaming && (sr_cnt != 3'd0);
    assign st_data          = sr[7:0];
    assign st_startofpacket = st_valid && sof_pend;
    assign st_endofpacket   = st_valid && (remaining == FRAME_BYTES_W'(1));

    assign xfer            = st_valid && st_ready;
    assign last_xfer       = xfer && (remaining == FRAME_BYTES_W'(1));
    assign sr_free         = (sr_cnt == 3'd0) || (xfer && (sr_cnt == 3'd1));
    assign avs_waitrequest = wr_data_req && streaming && hb_valid && !sr_free;
    assign data_acc        = wr_data_req && !avs_waitrequest;

`ifdef LCD_FRAME_STREAM_IRQ_EN
    assign irq = st_eof && irq_enable;
`endif

    always_comb begin
        avs_readdata = 32'd0;
        case (avs_address)
            ADDR_CONTROL: avs_readdata = {29'd0, irq_enable, 2'b00};
            ADDR_FRAME:   avs_readdata = 32'(frame_bytes);
            ADDR_STATUS:  avs_readdata = {REM_FIELD_W'(remaining), 4'd0,
                                          st_eof, st_zero_len, st_drop, streaming};
            default:      avs_readdata = 32'd0;
        endcase
    end

    logic unused_ok;
    assign unused_ok = &{1'b0, avs_read, avs_writedata};

    always_ff @(posedge wrclk or negedge wrreset_n) begin
        if (!wrreset_n) begin
            state       <= S_IDLE;
            frame_bytes <= '0;
            remaining   <= '0;
            sof_pend    <= 1'b0;
            hb_valid    <= 1'b0;
            hb          <= '0;
            sr          <= '0;
            sr_cnt      <= '0;
            st_drop     <= 1'b0;
            st_zero_len <= 1'b0;
            st_eof      <= 1'b0;
            irq_enable  <= 1'b0;
        end else begin
            if (wr_frame) frame_bytes <= avs_writedata[FRAME_BYTES_W-1:0];
            // write-one-to-clear; event sets below take precedence
            if (wr_stat) begin
                if (avs_writedata[1]) st_drop     <= 1'b0;
                if (avs_writedata[2]) st_zero_len <= 1'b0;
                if (avs_writedata[3]) st_eof      <= 1'b0;
            end
`ifdef LCD_FRAME_STREAM_IRQ_EN
            if (wr_ctrl) irq_enable <= avs_writedata[2];
`endif
            if (abort) begin
                state     <= S_IDLE;
                remaining <= '0;
                sof_pend  <= 1'b0;
                hb_valid  <= 1'b0;
                sr_cnt    <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            if (frame_bytes != '0) begin
                                state     <= S_STREAM;
                                remaining <= frame_bytes;
                                sof_pend  <= 1'b1;
                            end else begin
                                st_zero_len <= 1'b1;
                            end
                        end
                        if (data_acc) st_drop <= 1'b1;
                    end
                    S_STREAM: begin
                        if (xfer) begin
                            sof_pend <= 1'b0;
                            if (remaining != '0) remaining <= remaining - FRAME_BYTES_W'(1);
                        end
                        if (last_xfer) begin
                            // bytes past the frame length are discarded
                            state    <= S_IDLE;
                            st_eof   <= 1'b1;
                            hb_valid <= 1'b0;
                            sr_cnt   <= '0;
                        end else if (sr_free) begin
                            if (hb_valid) begin
                                sr       <= hb;
                                sr_cnt   <= 3'd4;
                                hb_valid <= data_acc;
                                if (data_acc) hb <= word_in;
                            end else if (data_acc) begin
                                sr     <= word_in;
                                sr_cnt <= 3'd4;
                            end else if (xfer) begin
                                sr     <= {8'd0, sr[31:8]};
                                sr_cnt <= 3'd0;
                            end
                        end else begin
                            if (xfer) begin
                                sr     <= {8'd0, sr[31:8]};
                                sr_cnt <= sr_cnt - 3'd1;
                            end
                            if (data_acc) begin
                                hb       <= word_in;
                                hb_valid <= 1'b1;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_lcd_frame_stream_source.sv
// Scoreboard bench for lcd_frame_stream_source: expected beats queued by stimulus, checked by a monitor.
module tb_lcd_frame_stream_source;
    logic        wrclk = 1'b0;
    logic        wrreset_n;
    logic [1:0]  avs_address;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic [7:0]  st_data;
    logic        st_valid;
    logic        st_startofpacket;
    logic        st_endofpacket;
    logic        st_ready;
`ifdef LCD_FRAME_STREAM_IRQ_EN
    logic        irq;
`endif

    lcd_frame_stream_source dut (
        .wrclk            (wrclk),
        .wrreset_n        (wrreset_n),
        .avs_address      (avs_address),
        .avs_write        (avs_write),
        .avs_writedata    (avs_writedata),
        .avs_read         (avs_read),
        .avs_readdata     (avs_readdata),
        .avs_waitrequest  (avs_waitrequest),
        .st_data          (st_data),
        .st_valid         (st_valid),
        .st_startofpacket (st_startofpacket),
        .st_endofpacket   (st_endofpacket),
        .st_ready         (st_ready)
`ifdef LCD_FRAME_STREAM_IRQ_EN
        ,
        .irq              (irq)
`endif
    );

    always #5 wrclk = ~wrclk;

    typedef struct packed {
        logic [7:0] d;
        logic       sop;
        logic       eop;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    sop_cyc = 0;
    int    eop_cyc = 0;
    bit    stall_chk_en = 1'b1;
    bit    tgl_on = 1'b0;

    always @(posedge wrclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic sop, input logic eop);
        exp_q.push_back('{d: d, sop: sop, eop: eop});
    endtask

    // Monitor: beats are sampled on the falling edge, ahead of the rising edge that moves them
    initial begin
        bit    held;
        beat_t hv;
        beat_t e;
        held = 1'b0;
        hv = '0;
        forever begin
            @(negedge wrclk);
            if (held && stall_chk_en)
                chk("stall_hold", 32'({st_valid, st_data, st_startofpacket, st_endofpacket}),
                    32'({1'b1, hv.d, hv.sop, hv.eop}));
            if (st_valid && st_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat: got data 0x%0h sop %0b eop %0b expected none",
                             st_data, st_startofpacket, st_endofpacket);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", 32'({st_data, st_startofpacket, st_endofpacket}), 32'(e));
                    if (st_startofpacket) sop_cyc = cyc;
                    if (st_endofpacket) eop_cyc = cyc;
                end
            end
            held = stall_chk_en && st_valid && !st_ready;
            hv = '{d: st_data, sop: st_startofpacket, eop: st_endofpacket};
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic mm_wr_w(input logic [1:0] a, input logic [31:0] d, output int waits);
        waits = 0;
        avs_address = a;
        avs_writedata = d;
        avs_write = 1'b1;
        @(negedge wrclk);
        while (avs_waitrequest && waits < 50) begin
            waits++;
            @(negedge wrclk);
        end
        if (avs_waitrequest) begin
            checks++;
            failures++;
            $display("FAIL wr_timeout: got waitrequest stuck addr %0d expected release", a);
        end
        @(posedge wrclk);
        #1;
        avs_write = 1'b0;
    endtask

    task automatic mm_wr(input logic [1:0] a, input logic [31:0] d);
        int w;
        mm_wr_w(a, d, w);
    endtask

    task automatic rd_chk(input logic [1:0] a, input logic [31:0] exp, input string name);
        avs_address = a;
        avs_read = 1'b1;
        #1;
        chk(name, avs_readdata, exp);
        avs_read = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || st_valid) && n < 100) begin
            @(posedge wrclk);
            n++;
        end
        #1;
        checks++;
        if (exp_q.size() != 0 || st_valid) begin
            failures++;
            $display("FAIL %s: got %0d beats pending expected 0", name, exp_q.size());
        end
    endtask

    initial begin
        int w1, w2, w3;
        bit pat[4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        wrreset_n = 1'b0;
        avs_address = 2'd0;
        avs_write = 1'b0;
        avs_writedata = 32'd0;
        avs_read = 1'b0;
        st_ready = 1'b1;
        repeat (3) @(posedge wrclk);
        #1;
        chk("rst_st_out", 32'({st_valid, st_startofpacket, st_endofpacket, st_data}), 32'd0);
        chk("rst_waitreq", 32'(avs_waitrequest), 32'd0);
        wrreset_n = 1'b1;
        @(posedge wrclk);
        #1;
        rd_chk(2'd3, 32'd0, "rst_status");
        rd_chk(2'd1, 32'd0, "rst_frame_bytes");

        // 8-byte frame, two words, ready always high
        mm_wr(2'd1, 32'd8);
        rd_chk(2'd1, 32'd8, "frame_bytes_rb");
        mm_wr(2'd0, 32'd1);
        rd_chk(2'd3, 32'h0000_0801, "status_busy");
        push(8'h11, 1, 0); push(8'h22, 0, 0); push(8'h33, 0, 0); push(8'h44, 0, 0);
        push(8'h55, 0, 0); push(8'h66, 0, 0); push(8'h77, 0, 0); push(8'h88, 0, 1);
        mm_wr(2'd2, 32'h4433_2211);
        chk("latency_n1", 32'(st_valid), 32'd1);
        mm_wr(2'd2, 32'h8877_6655);
        wait_drain("drain_f8");
        chk("f8_consecutive", 32'(eop_cyc - sop_cyc), 32'd7);
        rd_chk(2'd3, 32'h0000_0008, "f8_status_eof");
        mm_wr(2'd3, 32'hE);

        // 6-byte frame: last two bytes of second word discarded
        mm_wr(2'd1, 32'd6);
        mm_wr(2'd0, 32'd1);
        push(8'hAA, 1, 0); push(8'hBB, 0, 0); push(8'hCC, 0, 0);
        push(8'hDD, 0, 0); push(8'hEE, 0, 0); push(8'hFF, 0, 1);
        mm_wr(2'd2, 32'hDDCC_BBAA);
        mm_wr(2'd2, 32'h2211_FFEE);
        wait_drain("drain_f6");
        rd_chk(2'd3, 32'h0000_0008, "f6_status");
        mm_wr(2'd3, 32'hE);

        // Backpressure 1,0,0,1 with three back-to-back words
        mm_wr(2'd1, 32'd12);
        mm_wr(2'd0, 32'd1);
        for (int i = 0; i < 12; i++) push(8'(i), (i == 0), (i == 11));
        tgl_on = 1'b1;
        fork
            begin
                int k;
                k = 0;
                while (tgl_on) begin
                    st_ready = pat[k % 4];
                    k++;
                    @(posedge wrclk);
                    #1;
                end
            end
        join_none
        mm_wr_w(2'd2, 32'h0302_0100, w1);
        mm_wr_w(2'd2, 32'h0706_0504, w2);
        mm_wr_w(2'd2, 32'h0B0A_0908, w3);
        chk("wait_1st", 32'(w1), 32'd0);
        chk("wait_2nd", 32'(w2), 32'd0);
        chk("wait_3rd_stalls", 32'(w3 > 0), 32'd1);
        wait_drain("drain_bp");
        tgl_on = 1'b0;
        repeat (2) @(posedge wrclk);
        #1;
        st_ready = 1'b1;
        rd_chk(2'd3, 32'h0000_0008, "bp_status");
        mm_wr(2'd3, 32'hE);

        // Abort after 3 of 8 bytes
        st_ready = 1'b0;
        mm_wr(2'd1, 32'd8);
        mm_wr(2'd0, 32'd1);
        push(8'h11, 1, 0); push(8'h22, 0, 0); push(8'h33, 0, 0);
        mm_wr(2'd2, 32'h4433_2211);
        st_ready = 1'b1;
        repeat (3) @(posedge wrclk);
        #1;
        st_ready = 1'b0;
        chk("abort_sent3", 32'(exp_q.size()), 32'd0);
        stall_chk_en = 1'b0;
        mm_wr(2'd0, 32'd2);
        chk("abort_valid_low", 32'(st_valid), 32'd0);
        rd_chk(2'd3, 32'h0000_0000, "abort_status");
        stall_chk_en = 1'b1;
        st_ready = 1'b1;
        mm_wr(2'd1, 32'd4);
        mm_wr(2'd0, 32'd3);
        rd_chk(2'd3, 32'h0000_0000, "start_abort_is_abort");
        mm_wr(2'd0, 32'd1);
        push(8'hAA, 1, 0); push(8'hBB, 0, 0); push(8'hCC, 0, 0); push(8'hDD, 0, 1);
        mm_wr(2'd2, 32'hDDCC_BBAA);
        wait_drain("drain_resync");
        mm_wr(2'd3, 32'hE);

        // Zero length, idle DATA, single-byte frame
        mm_wr(2'd1, 32'd0);
        mm_wr(2'd0, 32'd1);
        repeat (2) @(posedge wrclk);
        #1;
        rd_chk(2'd3, 32'h0000_0004, "zero_len");
        mm_wr(2'd3, 32'hE);
        mm_wr(2'd2, 32'h1234_5678);
        repeat (2) @(posedge wrclk);
        #1;
        rd_chk(2'd3, 32'h0000_0002, "idle_drop");
        mm_wr(2'd3, 32'hE);
        rd_chk(2'd3, 32'h0000_0000, "w1c_cleared");
        mm_wr(2'd1, 32'd1);
        mm_wr(2'd0, 32'd1);
        push(8'hA5, 1, 1);
        mm_wr(2'd2, 32'h0000_00A5);
        wait_drain("drain_one");
        rd_chk(2'd3, 32'h0000_0008, "one_status");
        mm_wr(2'd3, 32'hE);

`ifdef LCD_FRAME_STREAM_IRQ_EN
        mm_wr(2'd1, 32'd1);
        mm_wr(2'd0, 32'd5);
        rd_chk(2'd0, 32'h0000_0004, "irq_en_rb");
        push(8'h5A, 1, 1);
        mm_wr(2'd2, 32'h0000_005A);
        wait_drain("drain_irq");
        chk("irq_rise", 32'(irq), 32'd1);
        mm_wr(2'd3, 32'h8);
        chk("irq_fall", 32'(irq), 32'd0);
`else
        mm_wr(2'd0, 32'd4);
        rd_chk(2'd0, 32'h0000_0000, "ctrl_reads_zero");
`endif

        // Asynchronous reset mid-frame
        st_ready = 1'b0;
        mm_wr(2'd1, 32'd8);
        mm_wr(2'd0, 32'd1);
        mm_wr(2'd2, 32'h4433_2211);
        chk("pre_reset_valid", 32'(st_valid), 32'd1);
        stall_chk_en = 1'b0;
        #2;
        wrreset_n = 1'b0;
        #1;
        chk("reset_outputs", 32'({st_valid, st_startofpacket, st_endofpacket, st_data}), 32'd0);
        rd_chk(2'd3, 32'h0000_0000, "reset_status");
        rd_chk(2'd1, 32'h0000_0000, "reset_frame_bytes");
        @(posedge wrclk);
        #1;
        wrreset_n = 1'b1;
        st_ready = 1'b1;
        repeat (3) @(posedge wrclk);
        #1;
        chk("post_reset_idle", 32'(st_valid), 32'd0);
        stall_chk_en = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
